// File: rtl/dot_matrix_scanner.sv
// ---------------------------------------------------------------------------
// dot_matrix_scanner
//   Row scanner for several LED dot-matrix panels that share their row lines.
//   The frame store is double-buffered. Game logic fills the back bank and
//   requests a swap. The banks exchange only on the last cycle of a frame, or
//   at once while idle, so a displayed frame is never torn.
//
// Optional feature (macro DOT_MATRIX_BLINK_EN):
//   This adds the input blink[PANELS] and the parameter BLINK_FRAMES. A blink
//   phase toggles every BLINK_FRAMES frames. A flagged panel shows dark
//   columns during the off phase.
//
// Ports:
//   clk_10000Hz  in   scan clock
//   reset        in   asynchronous, active-high reset
//   blink        in   per-panel blink enable (DOT_MATRIX_BLINK_EN only)
//   enable       in   scan enable; 0 forces the display dark and idle
//   wr_en        in   back-bank write strobe
//   wr_panel     in   target panel of the write
//   wr_row       in   target row of the write
//   wr_data      in   column pattern; bit COLS-1 is the leftmost LED
//   wr_ready     out  back bank accepts writes and swap requests
//   swap_req     in   request a front/back bank exchange
//   swap_ack     out  one-cycle pulse when the exchange happens
//   frame_start  out  one-cycle pulse on the first visible cycle of row 0
//   dot_row      out  shared row drive; row r maps to bit ROWS-1-r
//   dot_col      out  panel p on dot_col[p*COLS +: COLS]; 1 = LED on
// ---------------------------------------------------------------------------
module dot_matrix_scanner #(
   parameter int PANELS         = 2,
   parameter int ROWS           = 8,
   parameter int COLS           = 8,
   parameter int DWELL          = 1,
   parameter int BLANK          = 0,
   parameter int ROW_ACTIVE_LOW = 1,
`ifdef DOT_MATRIX_BLINK_EN
   parameter int BLINK_FRAMES   = 16,
`endif
   localparam int PW = (PANELS > 1) ? $clog2(PANELS) : 1,
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                     clk_10000Hz,
   input  logic                     reset,
`ifdef DOT_MATRIX_BLINK_EN
   input  logic [PANELS-1:0]        blink,
`endif
   input  logic                     enable,
   input  logic                     wr_en,
   input  logic [PW-1:0]            wr_panel,
   input  logic [RW-1:0]            wr_row,
   input  logic [COLS-1:0]          wr_data,
   output logic                     wr_ready,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     frame_start,
   output logic [ROWS-1:0]          dot_row,
   output logic [PANELS*COLS-1:0]   dot_col
);

   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
   localparam logic [ROWS-1:0] ROW_IDLE   = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

   typedef enum logic [1:0] {IDLE, SHOW, BLNK} state_t;

   state_t                 state_q, state_d;
   logic [RW-1:0]          row_q, row_d, row_next;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   front_q;
   logic                   pending_q;
   logic                   frame_last;
   logic                   swap_now;
   logic                   wr_hit;

   logic [ROWS-1:0]        row_sel;
   logic [ROWS-1:0]        dot_row_q, dot_row_d;
   logic [PANELS*COLS-1:0] dot_col_q, dot_col_d;
   logic                   swap_ack_q, frame_start_q;

   // Two banks of glyph rows, addressed by [bank][panel][row].
   logic [COLS-1:0]        mem_q [2][PANELS][ROWS];

`ifdef DOT_MATRIX_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] frame_cnt_q;
   logic          blink_on_q;
`endif

   assign row_next = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);

   // The swap point is the final cycle of the frame. That is the last blanking
   // cycle of the last row if blanking exists, else the last dwell cycle.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
      frame_last = 1'b0;
      if (BLANK > 0)
         frame_last = (state_q == BLNK) && (row_q == ROW_LAST) && (cnt_q == BLANK_LAST);
      else
         frame_last = (state_q == SHOW) && (row_q == ROW_LAST) && (cnt_q == DWELL_LAST);
   end

   assign swap_now = pending_q && (frame_last || (state_q == IDLE));
   assign wr_hit   = wr_en && !pending_q &&
                     (32'(wr_panel) < PANELS) && (32'(wr_row) < ROWS);

   // Next-state logic. Dropping enable overrides everything else.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            state_d = SHOW;
            row_d   = '0;
            cnt_d   = '0;
         end
         SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               if (BLANK > 0) begin
                  state_d = BLNK;
               end else begin
                  row_d = row_next;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         BLNK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               state_d = SHOW;
               row_d   = row_next;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d = IDLE;
         row_d   = '0;
         cnt_d   = '0;
      end
   end

   // The output drive is decoded from the current state and registered, so
   // row r becomes visible one cycle after the FSM enters SHOW(r).
   always_comb begin
      row_sel = '0;
      for (int r = 0; r < ROWS; r++)
         row_sel[ROWS-1-r] = (row_q == RW'(r));

      dot_row_d = ROW_IDLE;
      dot_col_d = '0;
      if (state_q == SHOW) begin
         dot_row_d = (ROW_ACTIVE_LOW != 0) ? ~row_sel : row_sel;
         for (int p = 0; p < PANELS; p++) begin
            dot_col_d[p*COLS +: COLS] = mem_q[front_q][p][row_q];
`ifdef DOT_MATRIX_BLINK_EN
            if (blink[p] && !blink_on_q)
               dot_col_d[p*COLS +: COLS] = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk_10000Hz or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         row_q         <= '0;
         cnt_q         <= '0;
         front_q       <= 1'b0;
         pending_q     <= 1'b0;
         dot_row_q     <= ROW_IDLE;
         dot_col_q     <= '0;
         swap_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         row_q         <= row_d;
         cnt_q         <= cnt_d;
         dot_row_q     <= dot_row_d;
         dot_col_q     <= dot_col_d;
         swap_ack_q    <= swap_now;
         frame_start_q <= (state_q == SHOW) && (row_q == '0) && (cnt_q == '0);
         if (swap_now) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
         end else if (swap_req && !pending_q) begin
            pending_q <= 1'b1;
         end
      end
   end

   // A write accepted together with swap_req still targets the old back bank,
   // because front_q only toggles when the swap executes.
   always_ff @(posedge clk_10000Hz or posedge reset) begin
      if (reset) begin
         // NOTE: this frame store is deliberately reset, so a restart never shows stale glyphs; that rules out a plain RAM macro.
         for (int b = 0; b < 2; b++)
            for (int p = 0; p < PANELS; p++)
               for (int r = 0; r < ROWS; r++)
                  mem_q[b][p][r] <= '0;
      end else if (wr_hit) begin
         mem_q[~front_q][wr_panel][wr_row] <= wr_data;
      end
   end

`ifdef DOT_MATRIX_BLINK_EN
   always_ff @(posedge clk_10000Hz or posedge reset) begin
      if (reset) begin
         frame_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (frame_last) begin
         if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
         end else begin
            frame_cnt_q <= frame_cnt_q + FW'(1);
         end
      end
   end
`endif

   assign wr_ready    = ~pending_q;
   assign swap_ack    = swap_ack_q;
   assign frame_start = frame_start_q;
   assign dot_row     = dot_row_q;
   assign dot_col     = dot_col_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_dot_matrix_scanner
//   Directed bench for dot_matrix_scanner. It builds two instances that share
//   their inputs. dut_a uses the default parameters. dut_b uses DWELL=3 and
//   BLANK=1. Inputs change 1 time unit after the rising edge, and outputs are
//   sampled at that same point.
// ---------------------------------------------------------------------------
module tb_dot_matrix_scanner;

   logic        clk_10000Hz = 1'b0;
   logic        reset;
   logic        enable;
   logic        wr_en;
   logic [0:0]  wr_panel;
   logic [2:0]  wr_row;
   logic [7:0]  wr_data;
   logic        swap_req;

   logic        wr_ready_a, swap_ack_a, frame_start_a;
   logic [7:0]  dot_row_a;
   logic [15:0] dot_col_a;
   logic        wr_ready_b, swap_ack_b, frame_start_b;
   logic [7:0]  dot_row_b;
   logic [15:0] dot_col_b;

   int checks = 0;
   int errors = 0;

   always #5 clk_10000Hz = ~clk_10000Hz;

   dot_matrix_scanner dut_a (
      .clk_10000Hz (clk_10000Hz),
      .reset       (reset),
      .enable      (enable),
      .wr_en       (wr_en),
      .wr_panel    (wr_panel),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready_a),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack_a),
      .frame_start (frame_start_a),
      .dot_row     (dot_row_a),
      .dot_col     (dot_col_a)
   );

   dot_matrix_scanner #(.DWELL(3), .BLANK(1)) dut_b (
      .clk_10000Hz (clk_10000Hz),
      .reset       (reset),
      .enable      (enable),
      .wr_en       (wr_en),
      .wr_panel    (wr_panel),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready_b),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack_b),
      .frame_start (frame_start_b),
      .dot_row     (dot_row_b),
      .dot_col     (dot_col_b)
   );

   typedef struct {
      logic        en;
      logic        we;
      logic [0:0]  pn;
      logic [2:0]  rw;
      logic [7:0]  dat;
      logic        sreq;
      logic [7:0]  e_row;
      logic [15:0] e_col;
      logic        e_rdy;
      logic        e_ack;
      logic        e_fs;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic en, input logic we, input logic [0:0] pn,
                               input logic [2:0] rw, input logic [7:0] dat, input logic sreq,
                               input logic [7:0] e_row, input logic [15:0] e_col,
                               input logic e_rdy, input logic e_ack, input logic e_fs);
      vec_t v;
      v.en = en; v.we = we; v.pn = pn; v.rw = rw; v.dat = dat; v.sreq = sreq;
      v.e_row = e_row; v.e_col = e_col; v.e_rdy = e_rdy; v.e_ack = e_ack; v.e_fs = e_fs;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_10000Hz);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en    = 1'b0;
      wr_panel = 1'b0;
      wr_row   = 3'd0;
      wr_data  = 8'h00;
      swap_req = 1'b0;
   endtask

   task automatic do_write(input logic [0:0] pn, input logic [2:0] rw, input logic [7:0] dat);
      wr_en = 1'b1; wr_panel = pn; wr_row = rw; wr_data = dat;
      tick();
      idle_inputs();
   endtask

   task automatic do_reset();
      @(negedge clk_10000Hz);
      reset = 1'b1;
      @(negedge clk_10000Hz);
      @(negedge clk_10000Hz);
      reset = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_row_a"},   {24'd0, dot_row_a}, 32'hFF);
      check({tag, "_col_a"},   {16'd0, dot_col_a}, 32'h0);
      check({tag, "_rdy_a"},   {31'd0, wr_ready_a}, 32'd1);
      check({tag, "_ack_a"},   {31'd0, swap_ack_a}, 32'd0);
      check({tag, "_fs_a"},    {31'd0, frame_start_a}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit          found;
      logic [7:0]  top_bit;
      logic [7:0]  exp_row;
      logic [15:0] exp_col;
      int          t;

      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 1'b1, 1'b0, 3'd0, 8'h3C, 1'b0, 8'h7F, 16'h0000, 1'b1, 1'b0, 1'b1);
      vecs[2]  = mk(1'b1, 1'b1, 1'b1, 3'd0, 8'h81, 1'b0, 8'hBF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'hDF, 16'h0000, 1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hEF, 16'h0000, 1'b0, 1'b0, 1'b0);
      vecs[5]  = mk(1'b1, 1'b1, 1'b0, 3'd1, 8'hFF, 1'b0, 8'hF7, 16'h0000, 1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'hFB, 16'h0000, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFD, 16'h0000, 1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFE, 16'h0000, 1'b1, 1'b1, 1'b0);
      vecs[9]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h7F, 16'h813C, 1'b1, 1'b0, 1'b1);
      vecs[10] = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hBF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hDF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hEF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[14] = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[15] = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h7F, 16'h813C, 1'b1, 1'b0, 1'b1);
      vecs[16] = mk(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hBF, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Reset state.
      reset  = 1'b1;
      enable = 1'b0;
      idle_inputs();
      #12;
      check_reset_outputs("reset");
      @(negedge clk_10000Hz);
      reset = 1'b0;
      tick();

      // Scan, write, mid-frame swap, blocked write and swap, and enable drop.
      for (int i = 0; i < 17; i++) begin
         enable   = vecs[i].en;
         wr_en    = vecs[i].we;
         wr_panel = vecs[i].pn;
         wr_row   = vecs[i].rw;
         wr_data  = vecs[i].dat;
         swap_req = vecs[i].sreq;
         tick();
         check($sformatf("vec%0d_row", i), {24'd0, dot_row_a}, {24'd0, vecs[i].e_row});
         check($sformatf("vec%0d_col", i), {16'd0, dot_col_a}, {16'd0, vecs[i].e_col});
         check($sformatf("vec%0d_rdy", i), {31'd0, wr_ready_a}, {31'd0, vecs[i].e_rdy});
         check($sformatf("vec%0d_ack", i), {31'd0, swap_ack_a}, {31'd0, vecs[i].e_ack});
         check($sformatf("vec%0d_fs", i),  {31'd0, frame_start_a}, {31'd0, vecs[i].e_fs});
      end
      idle_inputs();

      // Reset during row 5 with a swap pending. Back bank is bank 0 here.
      do_write(1'b0, 3'd0, 8'h12);
      wr_en = 1'b1; wr_panel = 1'b1; wr_row = 3'd0; wr_data = 8'h34; swap_req = 1'b1;
      tick();
      idle_inputs();
      check("pend_rdy", {31'd0, wr_ready_a}, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (dot_row_a == 8'hFB) found = 1'b1;
         else tick();
      end
      check("wait_row5", {31'd0, found}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk_10000Hz);
      @(negedge clk_10000Hz);
      reset  = 1'b0;
      enable = 1'b1;
      tick();
      tick();
      check("post_rst_row0", {24'd0, dot_row_a}, 32'h7F);
      check("post_rst_clear", {16'd0, dot_col_a}, 32'h0);
      check("post_rst_rdy", {31'd0, wr_ready_a}, 32'd1);
      check("post_rst_noack", {31'd0, swap_ack_a}, 32'd0);

      // Swap in IDLE with a write in the same cycle as swap_req.
      enable = 1'b0;
      tick();
      tick();
      do_write(1'b0, 3'd0, 8'h5A);
      wr_en = 1'b1; wr_panel = 1'b1; wr_row = 3'd0; wr_data = 8'hA5; swap_req = 1'b1;
      tick();
      idle_inputs();
      check("idle_pend_rdy", {31'd0, wr_ready_a}, 32'd0);
      check("idle_pend_ack", {31'd0, swap_ack_a}, 32'd0);
      tick();
      check("idle_swap_ack", {31'd0, swap_ack_a}, 32'd1);
      check("idle_swap_rdy", {31'd0, wr_ready_a}, 32'd1);
      enable = 1'b1;
      tick();
      check("idle_ack_drop", {31'd0, swap_ack_a}, 32'd0);
      tick();
      check("idle_row0", {24'd0, dot_row_a}, 32'h7F);
      check("idle_col0", {16'd0, dot_col_a}, 32'hA55A);
      check("idle_fs", {31'd0, frame_start_a}, 32'd1);

      // DWELL=3 / BLANK=1 on dut_b, with the default scan re-checked on dut_a.
      enable = 1'b0;
      do_reset();
      for (int r = 0; r < 8; r++) begin
         do_write(1'b0, 3'(r), 8'hFF);
         do_write(1'b1, 3'(r), 8'h01);
      end
      swap_req = 1'b1;
      tick();
      idle_inputs();
      tick();
      check("b_swap_ack", {31'd0, swap_ack_b}, 32'd1);
      enable = 1'b1;
      tick();
      top_bit = 8'h80;
      for (int k = 0; k < 64; k++) begin
         tick();
         t = k % 32;
         if ((t % 4) < 3) begin
            exp_row = ~(top_bit >> (t / 4));
            exp_col = 16'h01FF;
         end else begin
            exp_row = 8'hFF;
            exp_col = 16'h0000;
         end
         check($sformatf("b%0d_row", k), {24'd0, dot_row_b}, {24'd0, exp_row});
         check($sformatf("b%0d_col", k), {16'd0, dot_col_b}, {16'd0, exp_col});
         check($sformatf("b%0d_fs", k), {31'd0, frame_start_b}, (t == 0) ? 32'd1 : 32'd0);
         check($sformatf("a%0d_row", k), {24'd0, dot_row_a}, {24'd0, ~(top_bit >> (k % 8))});
         check($sformatf("a%0d_col", k), {16'd0, dot_col_a}, 32'h01FF);
         check($sformatf("a%0d_fs", k), {31'd0, frame_start_a}, ((k % 8) == 0) ? 32'd1 : 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
